pipelined_csel_adder: RTL and testbench

PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

---
 rtl/pipelined_csel_adder.sv | 187 ++++++++++++++++++
 tb/tb_pipelined_csel_adder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder: carry-select adder/subtractor split into
// WIDTH/(BLOCK*BPS) registered stages with valid/ready flow control.
module pipelined_csel_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 4,
  parameter int BPS   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int S = BLOCK * BPS;
  localparam int L = WIDTH / S;

  if ((WIDTH % S) != 0 || WIDTH < S) begin : g_bad_width
    $error("WIDTH must be a non-zero multiple of BLOCK*BPS");
  end

  // One stage slice: block 0 ripples, later blocks pick a
  // precomputed cin=0 / cin=1 result by the previous block carry.
  function automatic logic [S:0] csel(
    input logic [S-1:0] x,
    input logic [S-1:0] y,
    input logic         ci
  );
    logic [S-1:0] s;
    logic         c;
    logic [BLOCK:0] r0;
    logic [BLOCK:0] r1;
    s = '0;
    c = ci;
    for (int j = 0; j < BPS; j++) begin
      r0 = {1'b0, x[j*BLOCK +: BLOCK]}
         + {1'b0, y[j*BLOCK +: BLOCK]}
         + {{BLOCK{1'b0}}, (j == 0) ? c : 1'b0};
      r1 = {1'b0, x[j*BLOCK +: BLOCK]}
         + {1'b0, y[j*BLOCK +: BLOCK]}
         + {{BLOCK{1'b0}}, 1'b1};
      if (j == 0 || !c) begin
        s[j*BLOCK +: BLOCK] = r0[BLOCK-1:0];
        c = r0[BLOCK];
      end else begin
        s[j*BLOCK +: BLOCK] = r1[BLOCK-1:0];
        c = r1[BLOCK];
      end
    end
    return {c, s};
  endfunction

  logic stall;
  logic en;

  // Back-pressure: a held output freezes the whole pipe.
  always_comb begin
    stall    = out_valid && !out_ready;
    en       = !stall;
    in_ready = rst || !stall;
  end

  for (genvar k = 0; k < L; k++) begin : g_stg
    localparam int IW = WIDTH - k*S;

    logic [IW-1:0]      a_i;
    logic [IW-1:0]      bp_i;
    logic               c_i;
    logic               v_i;
    logic [S:0]         r;
    logic [(k+1)*S-1:0] s_d;
    logic [(k+1)*S-1:0] s_q;
    logic               c_d;
    logic               c_q;
    logic               v_d;
    logic               v_q;

    if (k == 0) begin : g_in
      // Effective operands: subtract is a + ~b + 1.
      always_comb begin
        a_i  = a;
        bp_i = sub ? ~b : b;
        c_i  = sub | cin;
        v_i  = in_valid && !rst;
      end
    end else begin : g_in
      // Pick up the skewed operands and carry of the prior stage.
      always_comb begin
        a_i  = g_stg[k-1].g_sk.a_q;
        bp_i = g_stg[k-1].g_sk.bp_q;
        c_i  = g_stg[k-1].c_q;
        v_i  = g_stg[k-1].v_q;
      end
    end

    if (k == 0) begin : g_s
      // First slice starts the de-skewed sum.
      always_comb s_d = r[S-1:0];
    end else begin : g_s
      // Append this slice above the already-resolved bits.
      always_comb s_d = {r[S-1:0], g_stg[k-1].s_q};
    end

    // Resolve this stage's S bits.
    always_comb begin
      r   = csel(a_i[S-1:0], bp_i[S-1:0], c_i);
      c_d = r[S];
      v_d = v_i;
    end

    // Stage carry, valid and partial sum.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= c_d;
        s_q <= s_d;
      end
    end

    if (k < L-1) begin : g_sk
      logic [IW-S-1:0] a_d;
      logic [IW-S-1:0] a_q;
      logic [IW-S-1:0] bp_d;
      logic [IW-S-1:0] bp_q;

      // Unresolved operand bits ride along.
      always_comb begin
        a_d  = a_i[IW-1:S];
        bp_d = bp_i[IW-1:S];
      end

      // Skew registers for the upper operand bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_q  <= '0;
          bp_q <= '0;
        end else if (en) begin
          a_q  <= a_d;
          bp_q <= bp_d;
        end
      end
    end else begin : g_fl
      logic ov_d;
      logic ov_q;
      logic z_d;
      logic z_q;

      // Flags come from the top slice and the full sum.
      always_comb begin
        ov_d = (a_i[IW-1] == bp_i[IW-1])
            && (r[S-1] != a_i[IW-1]);
        z_d  = (s_d == '0);
      end

      // Registered flags; zero resets high with sum at 0.
      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q <= 1'b0;
          z_q  <= 1'b1;
        end else if (en) begin
          ov_q <= ov_d;
          z_q  <= z_d;
        end
      end

      assign sum       = s_q;
      assign cout      = c_q;
      assign overflow  = ov_q;
      assign zero      = z_q;
      assign out_valid = v_q;
    end
  end

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb_pipelined_csel_adder: directed checks on the default
// configuration plus a parameter sweep against a reference model.
module tb_pipelined_csel_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] a, b;
  logic        cin, sub, in_valid, out_ready;
  logic        in_ready, cout, overflow, zero, out_valid;
  logic [31:0] sum;

  pipelined_csel_adder dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .cin(cin), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .sum(sum),
    .cout(cout), .overflow(overflow), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  logic [63:0] sw_a, sw_b;
  logic        sw_cin, sw_sub, sw_v, sw_or;
  logic        rdy0, rdy1, rdy2, vo0, vo1, vo2;
  logic        co0, co1, co2, of0, of1, of2, z0, z1, z2;
  logic [15:0] s0;
  logic [63:0] s1;
  logic [7:0]  s2;

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4), .BPS(1)) sw16 (
    .clk(clk), .rst(rst), .a(sw_a[15:0]), .b(sw_b[15:0]),
    .cin(sw_cin), .sub(sw_sub), .in_valid(sw_v), .in_ready(rdy0),
    .sum(s0), .cout(co0), .overflow(of0), .zero(z0),
    .out_valid(vo0), .out_ready(sw_or)
  );

  pipelined_csel_adder #(.WIDTH(64), .BLOCK(8), .BPS(2)) sw64 (
    .clk(clk), .rst(rst), .a(sw_a), .b(sw_b),
    .cin(sw_cin), .sub(sw_sub), .in_valid(sw_v), .in_ready(rdy1),
    .sum(s1), .cout(co1), .overflow(of1), .zero(z1),
    .out_valid(vo1), .out_ready(sw_or)
  );

  pipelined_csel_adder #(.WIDTH(8), .BLOCK(2), .BPS(4)) sw8 (
    .clk(clk), .rst(rst), .a(sw_a[7:0]), .b(sw_b[7:0]),
    .cin(sw_cin), .sub(sw_sub), .in_valid(sw_v), .in_ready(rdy2),
    .sum(s2), .cout(co2), .overflow(of2), .zero(z2),
    .out_valid(vo2), .out_ready(sw_or)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [66:0] model(input int w,
                                        input logic [63:0] x,
                                        input logic [63:0] y,
                                        input logic ci,
                                        input logic sb);
    logic [63:0] m, yp, s;
    logic [64:0] f;
    logic        co, ov;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                   : ((64'd1 << w) - 64'd1);
    yp = (sb ? ~y : y) & m;
    f  = {1'b0, x & m} + {1'b0, yp} + {64'd0, sb ? 1'b1 : ci};
    s  = f[63:0] & m;
    co = f[w];
    ov = (x[w-1] == yp[w-1]) && (s[w-1] != x[w-1]);
    return {s == 64'd0, ov, co, s};
  endfunction

  logic [66:0] q0[$], q1[$], q2[$];

  task automatic sb_step();
    if (sw_v && rdy0) q0.push_back(model(16, sw_a, sw_b, sw_cin, sw_sub));
    if (sw_v && rdy1) q1.push_back(model(64, sw_a, sw_b, sw_cin, sw_sub));
    if (sw_v && rdy2) q2.push_back(model(8, sw_a, sw_b, sw_cin, sw_sub));
    if (vo0 && sw_or) begin
      if (q0.size() == 0) check("sw16_spurious", vo0, 1'b0);
      else check("sw16", {z0, of0, co0, 48'd0, s0}, q0.pop_front());
    end
    if (vo1 && sw_or) begin
      if (q1.size() == 0) check("sw64_spurious", vo1, 1'b0);
      else check("sw64", {z1, of1, co1, s1}, q1.pop_front());
    end
    if (vo2 && sw_or) begin
      if (q2.size() == 0) check("sw8_spurious", vo2, 1'b0);
      else check("sw8", {z2, of2, co2, 56'd0, s2}, q2.pop_front());
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [31:0] ta, input logic [31:0] tb,
                        input logic tc, input logic ts,
                        input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez);
    int n;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check(tag, {zero, overflow, cout, sum}, {ez, eo, ec, es});
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int leak, got, stalls, extra, l0, l1, l2;

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    a = 32'h1234_5678; b = 32'h1; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    sw_v = 1'b0; sw_or = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_outputs", {zero, overflow, cout, sum}, {1'b1, 1'b0, 1'b0, 32'h0});
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0; in_valid = 1'b0;
    leak = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) leak++;
    end
    check("rst_no_accept", leak, 0);

    run_op("carry_chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    run_op("signed_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_cin_ign", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("add_cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);
    run_op("stage_carry", 32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    got = 0; stalls = 0; extra = 0;
    fork
      begin
        logic rdy;
        int   guard;
        for (int i = 0; i < 8; i++) begin
          a = 32'hFFFF_FFF0 + i; b = 32'h10; cin = 1'b0; sub = 1'b0;
          in_valid = 1'b1;
          rdy = 1'b0; guard = 0;
          while (!rdy && guard < 20) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk); #1;
            guard++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int t = 0; t < 40 && got < 8; t++) begin
          @(negedge clk);
          if (out_valid) begin
            check("bp_result", {zero, overflow, cout, sum},
                  {got == 0, 1'b0, 1'b1, 32'(got)});
            if (!out_ready) begin
              stalls++;
              check("bp_in_ready", in_ready, 1'b0);
            end else begin
              got++;
            end
          end
        end
        repeat (6) begin
          @(negedge clk);
          if (out_valid) extra++;
        end
      end
    join
    check("bp_count", got, 8);
    check("bp_stall_cycles", stalls, 3);
    check("bp_no_dup", extra, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h100 + i; b = 32'h1; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    leak = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) leak++;
      check("mid_rst_idle", out_valid, 1'b0);
    end
    check("mid_rst_leak", leak, 0);
    @(posedge clk); #1;
    run_op("mid_rst_new", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

    sw_a = 64'h0123_4567_89AB_CDEF; sw_b = 64'h1;
    sw_v = 1'b1; sw_or = 1'b1;
    @(posedge clk); #1;
    sw_v = 1'b0;
    l0 = 0; l1 = 0; l2 = 0;
    for (int n = 1; n <= 8; n++) begin
      if (vo0 && l0 == 0) l0 = n;
      if (vo1 && l1 == 0) l1 = n;
      if (vo2 && l2 == 0) l2 = n;
      @(posedge clk); #1;
    end
    check("sw16_lat", l0, 4);
    check("sw64_lat", l1, 4);
    check("sw8_lat", l2, 1);

    for (int t = 0; t < 10000; t++) begin
      sw_a   = {$urandom, $urandom};
      sw_b   = (t % 16 == 0) ? ~sw_a : {$urandom, $urandom};
      sw_cin = (t % 16 == 0) ? 1'b1 : 1'($urandom);
      sw_sub = (t % 16 == 0) ? 1'b0 : 1'($urandom);
      sw_v   = ($urandom % 4) != 0;
      sw_or  = ($urandom % 5) != 0;
      @(negedge clk);
      sb_step();
      @(posedge clk); #1;
    end
    sw_v = 1'b0; sw_or = 1'b1;
    repeat (8) begin
      @(negedge clk);
      sb_step();
      @(posedge clk); #1;
    end
    check("sw16_left", q0.size(), 0);
    check("sw64_left", q1.size(), 0);
    check("sw8_left", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
